// File: rtl/fir_dac_out.sv
// fir_dac_out: Avalon-ST sink for the FIR core's signed output stream,
// driving a parallel offset-binary DAC.
// Samples are buffered in a small FIFO and primed to half depth. They are
// then popped at a fixed rate, rounded half-up, shifted right by SHIFT and
// saturated to DOUT_W bits before reaching the DAC pins.
//
// Optional feature macro: FIR_DAC_MIDSCALE_ON_UNDERRUN_EN
//   defined   : entering underrun forces da_data to midscale with a da_valid pulse
//   undefined : da_data holds the last sample during underrun
//
// Ports:
//   sys_clk, sys_rst_n  clock, asynchronous active-low reset
//   ast_sink_*          Avalon-ST sink (data/valid/error in, ready out)
//   da_data             DAC code, offset binary
//   da_clk              inverted sys_clk; the DAC latches on the sys_clk falling edge
//   da_oe               DAC output enable, active-low, always enabled
//   da_valid            one-cycle pulse when da_data takes a new value
//   sat_flag            one-cycle pulse with da_valid when that sample saturated
//   underrun            sticky, set when a pop is due and the FIFO is empty
module fir_dac_out #(
  parameter int unsigned DIN_W      = 25,
  parameter int unsigned DOUT_W     = 10,
  parameter int unsigned SHIFT      = 14,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RATE_DIV   = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [DIN_W-1:0]  ast_sink_data,
  input  logic              ast_sink_valid,
  input  logic [1:0]        ast_sink_error,
  output logic              ast_sink_ready,
  output logic [DOUT_W-1:0] da_data,
  output logic              da_clk,
  output logic              da_oe,
  output logic              da_valid,
  output logic              sat_flag,
  output logic              underrun
);

  localparam int unsigned AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned RCW   = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam int unsigned PRIME = FIFO_DEPTH / 2;
  localparam int unsigned XW    = DIN_W + 1;

  localparam logic [CW-1:0]         CNT_FULL  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]         CNT_PRIME = CW'(PRIME);
  localparam logic [RCW-1:0]        RATE_LAST = RCW'(RATE_DIV - 1);
  localparam logic [XW-1:0]         HALF      = XW'(1) << (SHIFT - 1);
  localparam logic [DOUT_W-1:0]     MIDSCALE  = {1'b1, {(DOUT_W-1){1'b0}}};
  localparam logic [DOUT_W-1:0]     POS_FS    = {1'b0, {(DOUT_W-1){1'b1}}};
  localparam logic [DOUT_W-1:0]     NEG_FS    = {1'b1, {(DOUT_W-1){1'b0}}};
  localparam logic signed [XW-1:0]  SAT_HI    = XW'(POS_FS);
  localparam logic signed [XW-1:0]  SAT_LO    = ~SAT_HI;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_UNDER = 2'd2
  } state_t;

  // FIFO storage and control
  logic [DIN_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             empty;
  logic             accept;
  logic             push;
  logic             pop;

  // Pacing and sequencing
  logic [RCW-1:0]   rate_cnt;
  logic             tick;
  state_t           state;
  logic             underrun_set;

  // Datapath
  logic [DIN_W-1:0]        head;
  logic [XW-1:0]           x_ext;
  logic signed [XW-1:0]    x_rnd;
  logic signed [XW-1:0]    s1_r;
  logic                    s1_valid;
  logic [DOUT_W-1:0]       s2_s;
  logic                    s2_sat;
  logic [DOUT_W-1:0]       s2_code;
`ifdef FIR_DAC_MIDSCALE_ON_UNDERRUN_EN
  logic                    s1_mid;
`endif

  assign da_clk = ~sys_clk;
  assign da_oe  = 1'b0;

  // Handshake: error-tagged samples complete the handshake but are dropped
  assign empty     = (count == '0);
  assign accept    = ast_sink_valid && ast_sink_ready;
  assign push      = accept && (ast_sink_error == 2'b00);
  assign count_nxt = count + CW'(push) - CW'(pop);

  // Sample storage; no reset needed since occupancy is tracked by count
  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem[wr_ptr] <= ast_sink_data;
    end
  end

  // FIFO pointers, occupancy and registered ready
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      ast_sink_ready <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count          <= count_nxt;
      // Ready tracks !full of the count register it is updated alongside
      ast_sink_ready <= (count_nxt != CNT_FULL);
    end
  end

  // Free-running DAC rate counter
  assign tick = (rate_cnt == RATE_LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rate_cnt <= '0;
    end else if (tick) begin
      rate_cnt <= '0;
    end else begin
      rate_cnt <= rate_cnt + RCW'(1);
    end
  end

  // Pop and underrun decisions for the current state
  always_comb begin
    pop          = 1'b0;
    underrun_set = 1'b0;
    case (state)
      S_RUN: begin
        pop          = tick && !empty;
        underrun_set = tick && empty;
      end
      S_UNDER: begin
        pop = tick && !empty;
      end
      default: begin
      end
    endcase
  end

  // Sequencer: prime, run, and recover from underrun
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= S_IDLE;
      underrun <= 1'b0;
    end else begin
      if (underrun_set) begin
        underrun <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (count >= CNT_PRIME) begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (underrun_set) begin
            state <= S_UNDER;
          end
        end
        S_UNDER: begin
          if (pop) begin
            state <= S_RUN;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Stage 1: round half-up and arithmetic shift, one bit wider than the input
  assign head  = mem[rd_ptr];
  assign x_ext = {head[DIN_W-1], head};
  assign x_rnd = $signed(x_ext + HALF) >>> SHIFT;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1_r     <= '0;
      s1_valid <= 1'b0;
`ifdef FIR_DAC_MIDSCALE_ON_UNDERRUN_EN
      s1_mid   <= 1'b0;
`endif
    end else begin
      s1_valid <= pop;
      if (pop) begin
        s1_r <= x_rnd;
      end
`ifdef FIR_DAC_MIDSCALE_ON_UNDERRUN_EN
      // Midscale token travels the same path so it lands when a sample would have
      s1_mid   <= underrun_set;
`endif
    end
  end

  // Stage 2 combinational: saturate and convert to offset binary
  always_comb begin
    s2_s   = s1_r[DOUT_W-1:0];
    s2_sat = 1'b0;
    if (s1_r > SAT_HI) begin
      s2_s   = POS_FS;
      s2_sat = 1'b1;
    end else if (s1_r < SAT_LO) begin
      s2_s   = NEG_FS;
      s2_sat = 1'b1;
    end
    s2_code = {~s2_s[DOUT_W-1], s2_s[DOUT_W-2:0]};
  end

  // Stage 2 registers: DAC pins and status pulses
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      da_data  <= MIDSCALE;
      da_valid <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      da_valid <= s1_valid;
      sat_flag <= s1_valid && s2_sat;
      if (s1_valid) begin
        da_data <= s2_code;
      end
`ifdef FIR_DAC_MIDSCALE_ON_UNDERRUN_EN
      else if (s1_mid) begin
        da_data  <= MIDSCALE;
        da_valid <= 1'b1;
      end
`endif
    end
  end

endmodule
